// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT register file: register offsets, STATUS
// bit positions, sticky-bit layout and access FSM state encoding.
// Optional feature macro: USRT_REGFILE_IRQ_EN (adds the IRQ_EN register).
package usrt_pkg;

    // Register offsets on the 3-bit address bus
    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_TXDATA = 3'd2;
    localparam logic [2:0] ADDR_RXDATA = 3'd3;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd4;

    // STATUS bit positions
    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_PARITY_ERR = 2;
    localparam int ST_OVERRUN    = 3;
    localparam int ST_TX_OVF     = 4;

    // Sticky bits occupy a contiguous run of STATUS starting at STICKY_LSB
    localparam int STICKY_N   = 3;
    localparam int STICKY_LSB = ST_PARITY_ERR;

    // Bus access handshake FSM
    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_ACK  = 2'd1,
        FSM_HOLD = 2'd2
    } fsm_e;

    // True when the offset decodes to an implemented register
    function automatic logic addr_mapped(input logic [2:0] addr);
        logic hit;
        hit = (addr == ADDR_CTRL)   || (addr == ADDR_STATUS) ||
              (addr == ADDR_TXDATA) || (addr == ADDR_RXDATA);
`ifdef USRT_REGFILE_IRQ_EN
        hit = hit || (addr == ADDR_IRQ_EN);
`endif
        return hit;
    endfunction

endpackage

// File: rtl/usrt_w1c_bit.sv
// One sticky status cell: set by hardware, cleared by a write-one-to-clear
// strobe. A set in the same cycle as a clear wins so no event is lost.
module usrt_w1c_bit (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic q_d;
    logic q_q;

    // Next state: set has priority over clear
    always_comb begin
        q_d = q_q;
        if (set_i) begin
            q_d = 1'b1;
        end else if (clr_i) begin
            q_d = 1'b0;
        end
    end

    // Sticky state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/usrt_regfile.sv
// USRT register file: CTRL / STATUS / TXDATA / RXDATA behind a simple
// select/enable bus with a one-cycle ready pulse per access.
// Optional feature macro: USRT_REGFILE_IRQ_EN adds the IRQ_EN register at
// offset 4 and the o_Irq output; without it offset 4 is unmapped.
module usrt_regfile
    import usrt_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                BAUD_W   = 3,
    parameter logic [DATA_W-1:0] CTRL_RST = '0
) (
    input  logic              i_Pclk,
    input  logic              i_Reset_n,
    // Bus side
    input  logic              i_Sel,
    input  logic              i_Enable,
    input  logic              i_Pwrite,
    input  logic [2:0]        i_Addr,
    input  logic [DATA_W-1:0] i_Data,
    output logic [DATA_W-1:0] o_Rdata,
    output logic              o_Ready,
    output logic              o_Slverr,
    // Core side
    output logic [BAUD_W-1:0] o_Baud_sel,
    output logic              o_Parity_en,
    output logic              o_Parity_odd,
    output logic              o_Tx_en,
    output logic              o_Rx_en,
    output logic [DATA_W-1:0] o_Tx_data,
    output logic              o_Tx_wr,
    output logic              o_Rx_pop,
    input  logic [DATA_W-1:0] i_Rx_data,
    input  logic              i_Tx_busy,
    input  logic              i_Rx_valid,
    input  logic              i_Parity_err,
`ifdef USRT_REGFILE_IRQ_EN
    input  logic              i_Overrun,
    output logic              o_Irq
`else
    input  logic              i_Overrun
`endif
);

    localparam int CTRL_W = BAUD_W + 4;

    // ------------------------------------------------------------------
    // Access FSM
    // ------------------------------------------------------------------
    fsm_e state_q;
    fsm_e state_d;

    // A new access is only accepted from IDLE, so a held enable in HOLD
    // cannot start a second transfer.
    logic access_fire;
    logic wr_fire;
    logic rd_fire;

    assign access_fire = (state_q == FSM_IDLE) && i_Sel && i_Enable;
    assign wr_fire     = access_fire && i_Pwrite;
    assign rd_fire     = access_fire && !i_Pwrite;

    // FSM state register
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= FSM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FSM_IDLE: if (i_Sel && i_Enable) state_d = FSM_ACK;
            FSM_ACK:  state_d = FSM_HOLD;
            FSM_HOLD: if (!i_Enable || !i_Sel) state_d = FSM_IDLE;
            default:  state_d = FSM_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              slverr_q,  slverr_d;
    logic              tx_wr_q,   tx_wr_d;
    logic              rx_pop_q,  rx_pop_d;

    logic sel_ctrl;
    logic sel_status;
    logic sel_txdata;
    logic sel_rxdata;

    assign sel_ctrl   = (i_Addr == ADDR_CTRL);
    assign sel_status = (i_Addr == ADDR_STATUS);
    assign sel_txdata = (i_Addr == ADDR_TXDATA);
    assign sel_rxdata = (i_Addr == ADDR_RXDATA);

    // Sticky STATUS bits: parity_err, overrun, tx_ovf
    logic [STICKY_N-1:0] sticky_set;
    logic [STICKY_N-1:0] sticky_clr;
    logic [STICKY_N-1:0] sticky_q;
    logic                tx_ovf_set;

    // A TX write while the transmitter is busy is dropped and flagged
    assign tx_ovf_set = wr_fire && sel_txdata && i_Tx_busy;
    assign sticky_set = {tx_ovf_set, i_Overrun, i_Parity_err};

    generate
        for (genvar gi = 0; gi < STICKY_N; gi++) begin : g_sticky
            assign sticky_clr[gi] = wr_fire && sel_status && i_Data[STICKY_LSB + gi];

            usrt_w1c_bit u_w1c (
                .clk_i  (i_Pclk),
                .rst_ni (i_Reset_n),
                .set_i  (sticky_set[gi]),
                .clr_i  (sticky_clr[gi]),
                .q_o    (sticky_q[gi])
            );
        end
    endgenerate

    // Assemble the visible STATUS word: live bits plus sticky bits
    logic [DATA_W-1:0] status_word;
    always_comb begin
        status_word              = '0;
        status_word[ST_TX_BUSY]  = i_Tx_busy;
        status_word[ST_RX_VALID] = i_Rx_valid;
        status_word[STICKY_LSB +: STICKY_N] = sticky_q;
    end

`ifdef USRT_REGFILE_IRQ_EN
    logic [4:1] irq_en_q, irq_en_d;
    logic       irq_q,    irq_d;

    // IRQ enable next state and registered interrupt combine
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_fire && (i_Addr == ADDR_IRQ_EN)) begin
            irq_en_d = i_Data[4:1];
        end
        irq_d = |(status_word[4:1] & irq_en_q);
    end

    // IRQ enable and interrupt output registers
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign o_Irq = irq_q;
`endif

    // Read data mux; unmapped and write-only offsets read as zero
    logic [DATA_W-1:0] rd_word;
    always_comb begin
        rd_word = '0;
        case (i_Addr)
            ADDR_CTRL:   rd_word[CTRL_W-1:0] = ctrl_q;
            ADDR_STATUS: rd_word = status_word;
            ADDR_RXDATA: rd_word = i_Rx_data;
`ifdef USRT_REGFILE_IRQ_EN
            ADDR_IRQ_EN: rd_word[4:1] = irq_en_q;
`endif
            default:     rd_word = '0;
        endcase
    end

    // Next-state for all access-driven registers; everything commits on
    // the edge that enters ACK
    always_comb begin
        ctrl_d    = ctrl_q;
        tx_data_d = tx_data_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        tx_wr_d   = 1'b0;
        rx_pop_d  = 1'b0;
        if (access_fire) begin
            slverr_d = !addr_mapped(i_Addr);
            rdata_d  = rd_fire ? rd_word : '0;
        end
        if (wr_fire && sel_ctrl) begin
            ctrl_d = i_Data[CTRL_W-1:0];
        end
        if (wr_fire && sel_txdata && !i_Tx_busy) begin
            tx_data_d = i_Data;
            tx_wr_d   = 1'b1;
        end
        if (rd_fire && sel_rxdata && i_Rx_valid) begin
            rx_pop_d = 1'b1;
        end
    end

    // Register bank
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ctrl_q    <= CTRL_RST[CTRL_W-1:0];
            tx_data_q <= '0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            tx_wr_q   <= 1'b0;
            rx_pop_q  <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_data_q <= tx_data_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            tx_wr_q   <= tx_wr_d;
            rx_pop_q  <= rx_pop_d;
        end
    end

    // FSM outputs: handshake and pulses only exist while in ACK
    always_comb begin
        o_Ready  = (state_q == FSM_ACK);
        o_Slverr = (state_q == FSM_ACK) && slverr_q;
        o_Tx_wr  = (state_q == FSM_ACK) && tx_wr_q;
        o_Rx_pop = (state_q == FSM_ACK) && rx_pop_q;
    end

    // Core-facing fields come straight from register bits
    assign o_Rdata      = rdata_q;
    assign o_Tx_data    = tx_data_q;
    assign o_Baud_sel   = ctrl_q[BAUD_W-1:0];
    assign o_Parity_en  = ctrl_q[BAUD_W];
    assign o_Parity_odd = ctrl_q[BAUD_W+1];
    assign o_Tx_en      = ctrl_q[BAUD_W+2];
    assign o_Rx_en      = ctrl_q[BAUD_W+3];

endmodule

// File: tb/tb_usrt_regfile.sv
// Directed testbench for usrt_regfile (default parameters). IRQ checks are
// compiled in only when USRT_REGFILE_IRQ_EN is defined.
module tb_usrt_regfile;

    logic       i_Pclk;
    logic       i_Reset_n;
    logic       i_Sel, i_Enable, i_Pwrite;
    logic [2:0] i_Addr;
    logic [7:0] i_Data;
    logic [7:0] o_Rdata;
    logic       o_Ready, o_Slverr;
    logic [2:0] o_Baud_sel;
    logic       o_Parity_en, o_Parity_odd, o_Tx_en, o_Rx_en;
    logic [7:0] o_Tx_data;
    logic       o_Tx_wr, o_Rx_pop;
    logic [7:0] i_Rx_data;
    logic       i_Tx_busy, i_Rx_valid, i_Parity_err, i_Overrun;
`ifdef USRT_REGFILE_IRQ_EN
    logic       o_Irq;
`endif

    int checks = 0;
    int errors = 0;

    // Results of the most recent bus access
    logic [7:0] r_data;
    logic       r_err;
    int         n_rdy, n_txw, n_pop;

    usrt_regfile #(.DATA_W(8), .BAUD_W(3), .CTRL_RST(8'h00)) dut (
        .i_Pclk       (i_Pclk),
        .i_Reset_n    (i_Reset_n),
        .i_Sel        (i_Sel),
        .i_Enable     (i_Enable),
        .i_Pwrite     (i_Pwrite),
        .i_Addr       (i_Addr),
        .i_Data       (i_Data),
        .o_Rdata      (o_Rdata),
        .o_Ready      (o_Ready),
        .o_Slverr     (o_Slverr),
        .o_Baud_sel   (o_Baud_sel),
        .o_Parity_en  (o_Parity_en),
        .o_Parity_odd (o_Parity_odd),
        .o_Tx_en      (o_Tx_en),
        .o_Rx_en      (o_Rx_en),
        .o_Tx_data    (o_Tx_data),
        .o_Tx_wr      (o_Tx_wr),
        .o_Rx_pop     (o_Rx_pop),
        .i_Rx_data    (i_Rx_data),
        .i_Tx_busy    (i_Tx_busy),
        .i_Rx_valid   (i_Rx_valid),
        .i_Parity_err (i_Parity_err),
`ifdef USRT_REGFILE_IRQ_EN
        .i_Overrun    (i_Overrun),
        .o_Irq        (o_Irq)
`else
        .i_Overrun    (i_Overrun)
`endif
    );

    initial i_Pclk = 1'b0;
    always #5 i_Pclk = ~i_Pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One bus access; enable held for 'hold' sample cycles, then two idle
    // cycles so the FSM is back in IDLE on return. Outputs sampled on negedge.
    task automatic access(input logic [2:0] a, input logic w, input logic [7:0] d, input int hold);
        n_rdy = 0; n_txw = 0; n_pop = 0; r_data = '0; r_err = 1'b0;
        @(negedge i_Pclk);
        i_Sel = 1'b1; i_Enable = 1'b1; i_Pwrite = w; i_Addr = a; i_Data = d;
        for (int i = 0; i < hold + 2; i++) begin
            if (i == hold) begin
                i_Sel = 1'b0; i_Enable = 1'b0; i_Pwrite = 1'b0;
            end
            @(negedge i_Pclk);
            if (o_Ready) begin
                n_rdy++;
                r_data = o_Rdata;
                r_err  = o_Slverr;
            end
            if (o_Tx_wr)  n_txw++;
            if (o_Rx_pop) n_pop++;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        access(a, 1'b1, d, 1);
    endtask

    task automatic rd(input logic [2:0] a);
        access(a, 1'b0, 8'h00, 1);
    endtask

    initial begin
        i_Reset_n = 1'b0; i_Sel = 1'b0; i_Enable = 1'b0; i_Pwrite = 1'b0;
        i_Addr = '0; i_Data = '0; i_Rx_data = '0; i_Tx_busy = 1'b0;
        i_Rx_valid = 1'b0; i_Parity_err = 1'b0; i_Overrun = 1'b0;
        repeat (3) @(negedge i_Pclk);
        check("rst_ready",   o_Ready,   0);
        check("rst_rdata",   o_Rdata,   0);
        check("rst_txdata",  o_Tx_data, 0);
        i_Reset_n = 1'b1;

        // CTRL reset value and single-cycle ready
        rd(3'd0);
        check("ctrl_rst_rd",   r_data, 8'h00);
        check("ctrl_rst_rdy",  n_rdy,  1);
        check("ctrl_rst_err",  r_err,  0);

        // CTRL write and field decode
        wr(3'd0, 8'b0000_1101);
        check("baud_sel",   o_Baud_sel,   3'b101);
        check("parity_en",  o_Parity_en,  1);
        check("parity_odd", o_Parity_odd, 0);
        check("tx_en",      o_Tx_en,      0);
        check("rx_en",      o_Rx_en,      0);
        rd(3'd0);
        check("ctrl_rdback", r_data, 8'h0D);
        wr(3'd0, 8'hFF);
        rd(3'd0);
        check("ctrl_upper0", r_data, 8'h7F);

        // Sticky parity error, W1C, and set-beats-clear
        @(negedge i_Pclk); i_Parity_err = 1'b1;
        @(negedge i_Pclk); i_Parity_err = 1'b0;
        rd(3'd1);
        check("stat_perr_set", r_data, 8'h04);
        wr(3'd1, 8'h04);
        rd(3'd1);
        check("stat_perr_clr", r_data, 8'h00);
        i_Parity_err = 1'b1;
        wr(3'd1, 8'h04);
        i_Parity_err = 1'b0;
        rd(3'd1);
        check("stat_set_wins", r_data, 8'h04);
        wr(3'd1, 8'h04);

        // TXDATA load and overflow
        wr(3'd2, 8'hA5);
        check("txwr_pulse",  n_txw,     1);
        check("txdata_load", o_Tx_data, 8'hA5);
        rd(3'd2);
        check("txdata_rd0",  r_data,    8'h00);
        i_Tx_busy = 1'b1;
        wr(3'd2, 8'h3C);
        check("txwr_busy_nopulse", n_txw,     0);
        check("txdata_kept",       o_Tx_data, 8'hA5);
        wr(3'd1, 8'h03);
        rd(3'd1);
        check("stat_txovf", r_data, 8'h11);
        wr(3'd1, 8'h10);
        rd(3'd1);
        check("stat_txovf_clr", r_data, 8'h01);
        i_Tx_busy = 1'b0;

        // RXDATA read and pop
        i_Rx_valid = 1'b1; i_Rx_data = 8'h5A;
        rd(3'd3);
        check("rx_data", r_data, 8'h5A);
        check("rx_pop",  n_pop,  1);
        i_Rx_valid = 1'b0;
        rd(3'd3);
        check("rx_nopop", n_pop, 0);
        wr(3'd3, 8'hEE);
        check("rx_wr_noerr", r_err, 0);

        // Sticky overrun
        @(negedge i_Pclk); i_Overrun = 1'b1;
        @(negedge i_Pclk); i_Overrun = 1'b0;
        rd(3'd1);
        check("stat_overrun", r_data, 8'h08);

        // Unmapped read with enable held four cycles
        access(3'd6, 1'b0, 8'h00, 4);
        check("unmap_rdy_once", n_rdy,  1);
        check("unmap_slverr",   r_err,  1);
        check("unmap_rdata",    r_data, 8'h00);
        wr(3'd7, 8'h12);
        check("unmap_wr_err", r_err, 1);
        rd(3'd0);
        check("unmap_wr_ignored", r_data, 8'h7F);

`ifdef USRT_REGFILE_IRQ_EN
        wr(3'd1, 8'h08);
        wr(3'd4, 8'h08);
        check("irqen_err", r_err, 0);
        rd(3'd4);
        check("irqen_rd", r_data, 8'h08);
        check("irq_idle", o_Irq, 0);
        @(negedge i_Pclk); i_Overrun = 1'b1;
        @(negedge i_Pclk); i_Overrun = 1'b0;
        @(negedge i_Pclk);
        check("irq_set", o_Irq, 1);
        wr(3'd1, 8'h08);
        check("irq_clr", o_Irq, 0);
`else
        wr(3'd4, 8'h08);
        check("off4_unmapped", r_err, 1);
`endif

        // Reset arriving with an access pending: nothing commits
        @(negedge i_Pclk);
        i_Sel = 1'b1; i_Enable = 1'b1; i_Pwrite = 1'b1; i_Addr = 3'd0; i_Data = 8'h55;
        i_Reset_n = 1'b0;
        @(posedge i_Pclk); #1;
        check("abort_ready", o_Ready, 0);
        check("abort_txwr",  o_Tx_wr, 0);
        @(negedge i_Pclk);
        i_Sel = 1'b0; i_Enable = 1'b0; i_Pwrite = 1'b0;
        @(negedge i_Pclk);
        i_Reset_n = 1'b1;
        rd(3'd0);
        check("abort_ctrl", r_data, 8'h00);
        check("abort_txdata", o_Tx_data, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usrt_regfile.md
USRT_REGFILE -- requirements
Module: usrt_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bus and register width (>= 8).
REQ-002 SHALL have parameter BAUD_W, default 3, meaning baud-select field width (BAUD_W+4 <= DATA_W).
REQ-003 SHALL have parameter CTRL_RST, default 0, meaning CTRL reset value.
REQ-004 SHALL have ports: i_Pclk  in  1  clock, rising edge; i_Reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have bus ports: i_Sel in 1 select; i_Enable in 1 access phase; i_Pwrite in 1 write=1/read=0; i_Addr in 3 register offset; i_Data in DATA_W write data; o_Rdata out DATA_W read data; o_Ready out 1 access done; o_Slverr out 1 unmapped access.
REQ-006 SHALL have core ports: o_Baud_sel out BAUD_W; o_Parity_en, o_Parity_odd, o_Tx_en, o_Rx_en out 1; o_Tx_data out DATA_W; o_Tx_wr out 1 pulse; o_Rx_pop out 1 pulse; i_Rx_data in DATA_W; i_Tx_busy, i_Rx_valid, i_Parity_err, i_Overrun in 1.

Function
REQ-007 SHALL implement map: 0 CTRL rw; 1 STATUS ro/W1C; 2 TXDATA wo; 3 RXDATA ro; 4 IRQ_EN rw (macro only); others unmapped.
REQ-008 SHALL lay CTRL as [BAUD_W-1:0] baud, [BAUD_W] parity_en, [BAUD_W+1] parity_odd, [BAUD_W+2] tx_en, [BAUD_W+3] rx_en, upper bits read 0.
REQ-009 SHALL lay STATUS as [0] tx_busy live, [1] rx_valid live, [2] parity_err sticky, [3] overrun sticky, [4] tx_ovf sticky, upper bits 0.
REQ-010 SHALL run FSM IDLE -> ACK when i_Sel&&i_Enable; ACK -> HOLD unconditionally; HOLD -> IDLE when !i_Enable || !i_Sel, else stay.
REQ-011 SHALL assert o_Ready only in ACK: exactly one cycle per access, latency one cycle after access phase is sampled.
REQ-012 SHALL commit writes and capture o_Rdata on the edge entering ACK; o_Rdata held until next access.
REQ-013 SHALL accept no new access in HOLD, so a held i_Enable yields one access only.
REQ-014 SHALL, on unmapped access, assert o_Slverr with o_Ready, return 0, ignore write.
REQ-015 SHALL ignore writes to RXDATA and to STATUS bits 0-1; reads of TXDATA return 0.
REQ-016 SHALL, on STATUS write, clear sticky bits written 1; same-cycle hardware set wins over clear.
REQ-017 SHALL set sticky bits on any cycle their input (i_Parity_err, i_Overrun) is high.
REQ-018 SHALL, on TXDATA write with i_Tx_busy=0, load o_Tx_data and pulse o_Tx_wr in ACK; with i_Tx_busy=1 drop data, no pulse, set tx_ovf.
REQ-019 SHALL, on RXDATA read, return i_Rx_data and pulse o_Rx_pop in ACK only if i_Rx_valid=1.
REQ-020 SHALL drive CTRL fields to core outputs directly from register bits.

Reset
REQ-021 SHALL, while i_Reset_n=0, force FSM IDLE, CTRL=CTRL_RST, sticky bits 0, IRQ_EN 0, o_Tx_data 0, o_Rdata 0, and o_Ready, o_Slverr, o_Tx_wr, o_Rx_pop, o_Irq all 0.
REQ-022 SHALL abort an access in progress at reset with no write committed and no pulse emitted.

Configuration
REQ-023 SHALL, with USRT_REGFILE_IRQ_EN defined, add IRQ_EN register (bits [4:1] mirror STATUS) and output o_Irq out 1 = registered OR of (STATUS[4:1] & IRQ_EN[4:1]), one cycle after cause.
REQ-024 SHALL, without USRT_REGFILE_IRQ_EN, have no o_Irq port, and offset 4 is unmapped.

Structure
REQ-025 SHALL take register offsets, STATUS bit indices and FSM state encodings from shared package usrt_pkg.
REQ-026 SHALL instantiate sub-module usrt_w1c_bit (set/W1C/reset sticky cell) once per sticky status bit.

Verification
REQ-027 Reset then read CTRL -> o_Rdata=CTRL_RST, o_Ready one cycle, o_Slverr=0.
REQ-028 Write CTRL=8'b00001101 -> o_Baud_sel=3'b101, o_Parity_en=1, others 0; readback 8'h0D.
REQ-029 Pulse i_Parity_err, read STATUS -> bit2=1; write 8'h04 -> bit2=0; clear coinciding with i_Parity_err -> bit2 stays 1.
REQ-030 Write TXDATA=8'hA5 with i_Tx_busy=0 -> o_Tx_wr one pulse, o_Tx_data=8'hA5; repeat with i_Tx_busy=1 -> no pulse, STATUS bit4=1.
REQ-031 Read addr 6 with i_Enable held 4 cycles -> single o_Ready with o_Slverr=1, o_Rdata=0, no second access.
REQ-032 With macro: IRQ_EN=8'h08, pulse i_Overrun -> o_Irq=1 next cycle; W1C bit3 -> o_Irq=0.
